ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage of the 5-stage RV32 pipeline; consumes the ID/EX register outputs directly.
//  Forwards operands from EX/MEM and MEM/WB, computes single-cycle ALU results combinationally.
//  Runs MUL/MULHU/DIVU/REMU on an iterative 32-step FSM and holds the front end with stall.
// PARAMETERS
//  XLEN         32  datapath width; only 32 is supported
//  LONG_OPS_EN  1   1: iterative mul/div unit present; 0: msg 10..13 yield 0 in one cycle, stall never asserts
// PORTS
//  clk            in   1   clock
//  rst            in   1   asynchronous, active-low reset
//  rs1, rs2       in   5   source register indices from ID/EX
//  rd             in   5   destination index
//  rs1_v, rs2_v   in   32  operand values; rs2_v is the immediate when ctl[4]=1
//  msg            in   4   ALU op: 0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,
//                          10 MUL,11 MULHU,12 DIVU,13 REMU,14 PASSB,15 AUIPC(pc+B)
//  ctl            in   5   [0] valid, [1] reg_write, [2] mem_read, [3] mem_write, [4] B is immediate
//  pc             in   32  instruction PC
//  exm_rd, exm_v, exm_we  in 5/32/1  EX/MEM forwarding source
//  mwb_rd, mwb_v, mwb_we  in 5/32/1  MEM/WB forwarding source
//  alu_result     out  32  result to EX/MEM
//  store_data     out  32  forwarded rs2 value, also used when ctl[4]=1
//  rd_out         out  5   destination index passthrough
//  we_out, mr_out, mw_out  out 1  reg_write/mem_read/mem_write, gated by valid_out
//  valid_out      out  1   result valid this cycle
//  stall          out  1   hold PC/IF-ID/ID-EX; EX/MEM captures a bubble
// BEHAVIOUR
//  Reset: FSM=IDLE; cnt, acc, opA/opB latches = 0; stall=0, valid_out=0, we/mr/mw=0.
//   Reset mid-operation aborts the op: IDLE, no result emitted.
//  Forwarding (A from rs1; B from rs2, and store_data from rs2 always):
//   - source index 0 never forwards;
//   - EX/MEM match with exm_we beats MEM/WB match with mwb_we;
//   - otherwise use the register value.
//  B operand = rs2_v when ctl[4]=1, else the forwarded rs2.
//  Single-cycle ops (msg 0..9,14,15): combinational, zero added latency; stall=0; valid_out=ctl[0].
//  Shifts use B[4:0]; SRA is arithmetic; SLT is signed, SLTU unsigned; ADD/SUB wrap mod 2^32.
//  Long ops (msg 10..13, ctl[0]=1, LONG_OPS_EN=1), FSM IDLE->BUSY->DONE->IDLE:
//   - IDLE, cycle 0: latch forwarded A/B and op, cnt=0, stall=1, valid_out=0; go BUSY.
//   - BUSY: one shift-add (mul) or restoring-subtract (div) step per cycle; stall=1, valid_out=0.
//     After step cnt==31 (32 steps), go DONE.
//   - DONE: stall=0, valid_out=1, alu_result=latched result; go IDLE unconditionally.
//   - Stall is high for exactly 33 cycles; the instruction occupies EX for 34 cycles.
//   - Inputs during BUSY are ignored (ID/EX is held); later forwarding changes do not affect the op.
//  MUL = low 32 bits of the product; MULHU = high 32 bits of the unsigned product.
//  DIVU by 0 -> 0xFFFFFFFF; REMU by 0 -> dividend (natural restoring result, no special case).
//  Bubble (ctl[0]=0): no FSM start; valid_out=0, we/mr/mw=0; alu_result is don't-care.
//  rd_out=rd always; we_out=ctl[1]&valid_out, and likewise mr_out, mw_out.
//  AUIPC: pc+B. PASSB (LUI): B.
// TESTING
//  1 ADD rs1=x5 with exm_we=1, exm_rd=5, exm_v=10, rs2_v=3, ctl[4]=0 -> alu_result=13, stall=0.
//  2 exm_rd=mwb_rd=5 (10 and 20, both we=1) -> EX/MEM wins (10); rs1=x0 with exm_rd=0 -> 0 used.
//  3 DIVU 100/7 -> stall high cycles 0..32, valid_out=1 at cycle 33, result 14; REMU -> 2.
//  4 DIVU 0x1234/0 -> 0xFFFFFFFF; REMU -> 0x1234; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
//  5 SRA 0x80000000 by 31 -> 0xFFFFFFFF; SLT -1<1 -> 1; SLTU 0xFFFFFFFF<1 -> 0.
//  6 rst low at BUSY cycle 10 -> stall=0, valid_out=0 at once; after release a new ADD completes in 1 cycle.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, and an iterative 32-step
// mul/div unit that stalls the front end while a long op is in flight.
module ex_stage #(
  parameter int unsigned XLEN        = 32,
  parameter bit          LONG_OPS_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] rs1_v,
  input  logic [XLEN-1:0] rs2_v,
  input  logic [3:0]      msg,
  input  logic [4:0]      ctl,
  input  logic [XLEN-1:0] pc,
  input  logic [4:0]      exm_rd,
  input  logic [XLEN-1:0] exm_v,
  input  logic            exm_we,
  input  logic [4:0]      mwb_rd,
  input  logic [XLEN-1:0] mwb_v,
  input  logic            mwb_we,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] store_data,
  output logic [4:0]      rd_out,
  output logic            we_out,
  output logic            mr_out,
  output logic            mw_out,
  output logic            valid_out,
  output logic            stall
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned ACC_W = 2 * XLEN;
  localparam int unsigned SUM_W = XLEN + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc, acc_step;
  logic [XLEN-1:0]   op_a, op_b_q;
  logic              op_div, op_hi;

  logic [XLEN-1:0]   a_fwd, b_fwd, b_opnd, alu_c, long_res;
  logic [SUM_W-1:0]  mul_sum, div_rem, div_diff;
  logic              is_long, start;

  // Forwarding: EX/MEM has priority over MEM/WB; x0 never forwards
  always_comb begin
    a_fwd = rs1_v;
    if (rs1 != 5'd0 && exm_we && exm_rd == rs1)      a_fwd = exm_v;
    else if (rs1 != 5'd0 && mwb_we && mwb_rd == rs1) a_fwd = mwb_v;
    b_fwd = rs2_v;
    if (rs2 != 5'd0 && exm_we && exm_rd == rs2)      b_fwd = exm_v;
    else if (rs2 != 5'd0 && mwb_we && mwb_rd == rs2) b_fwd = mwb_v;
  end

  assign b_opnd  = ctl[4] ? rs2_v : b_fwd;
  assign is_long = (msg >= 4'd10) && (msg <= 4'd13);
  assign start   = LONG_OPS_EN && ctl[0] && is_long && (state == S_IDLE);

  // Single-cycle ALU; long-op codes fall to zero here
  always_comb begin
    alu_c = '0;
    unique case (msg)
      4'd0:    alu_c = a_fwd + b_opnd;
      4'd1:    alu_c = a_fwd - b_opnd;
      4'd2:    alu_c = a_fwd << b_opnd[4:0];
      4'd3:    alu_c = XLEN'($signed(a_fwd) < $signed(b_opnd));
      4'd4:    alu_c = XLEN'(a_fwd < b_opnd);
      4'd5:    alu_c = a_fwd ^ b_opnd;
      4'd6:    alu_c = a_fwd >> b_opnd[4:0];
      4'd7:    alu_c = XLEN'($signed(a_fwd) >>> b_opnd[4:0]);
      4'd8:    alu_c = a_fwd | b_opnd;
      4'd9:    alu_c = a_fwd & b_opnd;
      4'd14:   alu_c = b_opnd;
      4'd15:   alu_c = pc + b_opnd;
      default: alu_c = '0;
    endcase
  end

  // One shift-add (mul) or restoring-subtract (div) step on {hi, lo}
  always_comb begin
    mul_sum  = {1'b0, acc[ACC_W-1:XLEN]} + (acc[0] ? {1'b0, op_a} : SUM_W'(0));
    div_rem  = acc[ACC_W-1:XLEN-1];
    div_diff = div_rem - {1'b0, op_b_q};
    if (!op_div)              acc_step = {mul_sum, acc[XLEN-1:1]};
    else if (!div_diff[XLEN]) acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else                      acc_step = {div_rem[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  end

  assign long_res = op_hi ? acc[ACC_W-1:XLEN] : acc[XLEN-1:0];

  // Long-op operand latches and accumulator
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      acc    <= '0;
      op_a   <= '0;
      op_b_q <= '0;
      op_div <= 1'b0;
      op_hi  <= 1'b0;
    end else if (start) begin
      cnt    <= '0;
      op_a   <= a_fwd;
      op_b_q <= b_opnd;
      op_div <= msg[2];
      op_hi  <= msg[0];
      acc    <= {XLEN'(0), (msg[2] ? a_fwd : b_opnd)};
    end else if (state == S_BUSY) begin
      cnt <= cnt + CNT_W'(1);
      acc <= acc_step;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_BUSY;
      S_BUSY:  if (cnt == CNT_W'(XLEN - 1)) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs; held quiet while reset is asserted even if ID/EX still carries an op
  always_comb begin
    stall      = 1'b0;
    valid_out  = ctl[0];
    alu_result = alu_c;
    unique case (state)
      S_IDLE: if (start) begin
        stall     = 1'b1;
        valid_out = 1'b0;
      end
      S_BUSY: begin
        stall     = 1'b1;
        valid_out = 1'b0;
      end
      S_DONE: begin
        valid_out  = 1'b1;
        alu_result = long_res;
      end
      default: ;
    endcase
    if (!rst) begin
      stall     = 1'b0;
      valid_out = 1'b0;
    end
  end

  assign store_data = b_fwd;
  assign rd_out     = rd;
  assign we_out     = ctl[1] & valid_out;
  assign mr_out     = ctl[2] & valid_out;
  assign mw_out     = ctl[3] & valid_out;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: forwarding, ALU ops, long-op timing and reset abort.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1, rs2, rd, exm_rd, mwb_rd;
  logic [31:0] rs1_v, rs2_v, pc, exm_v, mwb_v;
  logic [3:0]  msg;
  logic [4:0]  ctl;
  logic        exm_we, mwb_we;
  logic [31:0] alu_result, store_data;
  logic [4:0]  rd_out;
  logic        we_out, mr_out, mw_out, valid_out, stall;

  int errors = 0;
  int checks = 0;

  ex_stage dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd),
    .rs1_v(rs1_v), .rs2_v(rs2_v), .msg(msg), .ctl(ctl), .pc(pc),
    .exm_rd(exm_rd), .exm_v(exm_v), .exm_we(exm_we),
    .mwb_rd(mwb_rd), .mwb_v(mwb_v), .mwb_we(mwb_we),
    .alu_result(alu_result), .store_data(store_data), .rd_out(rd_out),
    .we_out(we_out), .mr_out(mr_out), .mw_out(mw_out),
    .valid_out(valid_out), .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] c);
    rs1 = 5'd1; rs2 = 5'd2; rd = 5'd9;
    rs1_v = a; rs2_v = b; msg = op; ctl = c;
    exm_we = 1'b0; mwb_we = 1'b0;
  endtask

  task automatic run_alu(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    set_op(op, a, b, 5'b00011);
    #1;
    check(tag, alu_result, exp);
    tick();
  endtask

  // Long op: expects 33 stall cycles then one valid result cycle
  task automatic run_long(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    int n;
    set_op(op, a, b, 5'b00011);
    #1;
    check({tag, "_stall0"}, 32'(stall), 32'd1);
    check({tag, "_valid0"}, 32'(valid_out), 32'd0);
    n = 0;
    while (stall && n < 100) begin
      tick();
      n++;
      if (n == 5) begin
        rs1_v = 32'hDEAD_BEEF;
        rs2_v = 32'h0000_0003;
      end
    end
    check({tag, "_stall_cycles"}, 32'(n), 32'd33);
    check({tag, "_valid"}, 32'(valid_out), 32'd1);
    check({tag, "_result"}, alu_result, exp);
    ctl = 5'b00000;
    tick();
  endtask

  initial begin
    rst = 1'b0;
    pc = 32'h0; exm_rd = 5'd0; exm_v = 32'h0; mwb_rd = 5'd0; mwb_v = 32'h0;
    set_op(4'd0, 32'd1, 32'd2, 5'b00011);
    #2;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_we", 32'(we_out), 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Forwarding
    set_op(4'd0, 32'd99, 32'd3, 5'b00011);
    rs1 = 5'd5; rs2 = 5'd6; exm_rd = 5'd5; exm_v = 32'd10; exm_we = 1'b1;
    #1;
    check("fwd_exm_add", alu_result, 32'd13);
    check("fwd_exm_stall", 32'(stall), 32'd0);
    check("fwd_exm_we", 32'(we_out), 32'd1);
    check("rd_out", 32'(rd_out), 32'd9);
    mwb_rd = 5'd5; mwb_v = 32'd20; mwb_we = 1'b1;
    #1;
    check("fwd_priority", alu_result, 32'd13);
    exm_we = 1'b0;
    #1;
    check("fwd_mwb", alu_result, 32'd23);
    rs1 = 5'd0; rs1_v = 32'd0; exm_rd = 5'd0; exm_we = 1'b1; mwb_rd = 5'd0;
    #1;
    check("fwd_x0", alu_result, 32'd3);
    tick();

    // Immediate B with forwarded store data
    set_op(4'd0, 32'd1, 32'd4, 5'b11001);
    rs2 = 5'd7; exm_rd = 5'd7; exm_v = 32'h55; exm_we = 1'b1;
    #1;
    check("imm_add", alu_result, 32'd5);
    check("store_fwd", store_data, 32'h55);
    check("store_mw", 32'(mw_out), 32'd1);
    check("store_we", 32'(we_out), 32'd0);
    tick();
    set_op(4'd0, 32'd1, 32'd4, 5'b00101);
    #1;
    check("load_mr", 32'(mr_out), 32'd1);
    tick();

    // Single-cycle ALU ops
    run_alu("sub", 4'd1, 32'd3, 32'd5, 32'hFFFF_FFFE);
    run_alu("sll", 4'd2, 32'd1, 32'd36, 32'd16);
    run_alu("slt", 4'd3, 32'hFFFF_FFFF, 32'd1, 32'd1);
    run_alu("sltu", 4'd4, 32'hFFFF_FFFF, 32'd1, 32'd0);
    run_alu("xor", 4'd5, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0);
    run_alu("srl", 4'd6, 32'h8000_0000, 32'd31, 32'd1);
    run_alu("or", 4'd8, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0);
    run_alu("and", 4'd9, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
    run_alu("passb", 4'd14, 32'd7, 32'h1234_5000, 32'h1234_5000);
    pc = 32'h1000;
    run_alu("auipc", 4'd15, 32'd7, 32'h20, 32'h1020);
    set_op(4'd7, 32'h8000_0000, 32'd31, 32'b10011);
    #1;
    check("sra_imm", alu_result, 32'hFFFF_FFFF);
    tick();

    // Bubble
    set_op(4'd0, 32'd1, 32'd2, 5'b00010);
    #1;
    check("bubble_valid", 32'(valid_out), 32'd0);
    check("bubble_we", 32'(we_out), 32'd0);
    set_op(4'd12, 32'd100, 32'd7, 5'b00010);
    #1;
    check("bubble_long_stall", 32'(stall), 32'd0);
    tick();
    check("bubble_long_idle", 32'(stall), 32'd0);

    // Long ops
    run_long("divu", 4'd12, 32'd100, 32'd7, 32'd14);
    run_long("remu", 4'd13, 32'd100, 32'd7, 32'd2);
    run_long("mul", 4'd10, 32'd123, 32'd456, 32'd56088);
    run_long("divu0", 4'd12, 32'h1234, 32'd0, 32'hFFFF_FFFF);
    run_long("remu0", 4'd13, 32'h1234, 32'd0, 32'h1234);
    run_long("mulhu", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    // Reset during BUSY aborts the op
    set_op(4'd12, 32'd100, 32'd7, 5'b00011);
    for (int i = 0; i < 10; i++) tick();
    check("busy_stall", 32'(stall), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_stall", 32'(stall), 32'd0);
    check("abort_valid", 32'(valid_out), 32'd0);
    set_op(4'd0, 32'd2, 32'd3, 5'b00011);
    tick(); tick();
    rst = 1'b1;
    #1;
    check("post_rst_add", alu_result, 32'd5);
    check("post_rst_valid", 32'(valid_out), 32'd1);
    check("post_rst_stall", 32'(stall), 32'd0);
    tick();
    check("post_rst_idle", 32'(stall), 32'd0);
    check("post_rst_add2", alu_result, 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
